// File: rtl/slice_pkg.sv
// Shared definitions for the Focus (space-to-depth) slice controller.
// Latency: n/a (types, constants and a quadrant-offset helper only).
// Backpressure: n/a.
package slice_pkg;

    // Default element width of the feature-map buffers.
    localparam int SLICE_DATA_WIDTH = 16;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Quadrant offsets, indexed by quadrant number q:
    // q0 (0,0), q1 (0,1), q2 (1,0), q3 (1,1) as (dy,dx).
    localparam logic [3:0] QUAD_DY = 4'b1100;
    localparam logic [3:0] QUAD_DX = 4'b1010;

    // Source offset of a quadrant's first element: dy*width + dx.
    // dy/dx are single bits, so this reduces to a mux and a small add.
    function automatic int quad_offset(input logic [1:0] q, input int width);
        int off;
        off = 0;
        if (QUAD_DY[q]) off = off + width;
        if (QUAD_DX[q]) off = off + 1;
        return off;
    endfunction

endpackage

// File: rtl/slice_ofifo.sv
// Two-entry output FIFO holding {write address, data} pairs for the slice stream.
// Latency: push visible at head the cycle after the push edge; no fall-through.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports: clk/rst (async active-high), push/push_addr/push_data in,
//        pop in, head_addr/head_data out, count/full/empty status out.
module slice_ofifo
    import slice_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [1:0]    count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_data [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    // Storage is cleared on reset so the head reads as zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr[0] <= '0;
            r_addr[1] <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (push) begin
                r_addr[r_wr_ptr] <= push_addr;
                r_data[r_wr_ptr] <= push_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && (r_count == 2'd0)));
        end
    end

    assign head_addr = r_addr[r_rd_ptr];
    assign head_data = r_data[r_rd_ptr];
    assign count     = r_count;
    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);

endmodule

// File: rtl/slice_ctrl.sv
// Focus/space-to-depth slice: reads a WxHxK CHW tensor, writes 4K channels of (W/2)x(H/2).
// Latency: first write valid 3 cycles after start accept; done at N+3, 1 element/cycle.
// Backpressure: wr_ready low stops reads; at most 2 elements buffered, head held stable.
//
// Ports: clk, rst (async active-high), start/src_base/dst_base (frame request),
//        busy/done status, rd_en/rd_addr/rd_data (sync RAM, 1-cycle read),
//        wr_valid/wr_ready/wr_addr/wr_data (valid-ready write stream).
module slice_ctrl
    import slice_pkg::*;
#(
    parameter int W          = 4,
    parameter int H          = 4,
    parameter int K          = 3,
    parameter int DATA_WIDTH = SLICE_DATA_WIDTH,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int HALF_W = W / 2;
    localparam int HALF_H = H / 2;
    localparam int OXW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int OYW    = (HALF_H > 1) ? $clog2(HALF_H) : 1;
    localparam int CW     = (K > 1) ? $clog2(K) : 1;

    localparam logic [OXW-1:0]        OX_LAST  = OXW'(HALF_W - 1);
    localparam logic [OYW-1:0]        OY_LAST  = OYW'(HALF_H - 1);
    localparam logic [CW-1:0]         C_LAST   = CW'(K - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(2 * W);
    localparam logic [ADDR_WIDTH-1:0] CH_STEP  = ADDR_WIDTH'(W * H);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_q;
    logic [CW-1:0]         r_c;
    logic [OYW-1:0]        r_oy;
    logic [OXW-1:0]        r_ox;
    logic [ADDR_WIDTH-1:0] r_src_base;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_row_base;   // read address of the current output row's ox=0
    logic [ADDR_WIDTH-1:0] r_chan_base;  // read address of the current channel's oy=0,ox=0
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;
    logic                  r_inflight;   // a read was issued last cycle; its data is on rd_data now

    logic                  w_last;
    logic                  w_pop;
    logic                  w_rd_en;
    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_count;
    logic [2:0]            w_occ;
    logic [ADDR_WIDTH-1:0] w_next_quad;

    assign w_last      = (r_q == 2'd3) && (r_c == C_LAST) && (r_oy == OY_LAST) && (r_ox == OX_LAST);
    assign w_pop       = !w_empty && wr_ready;
    // Slots committed after this cycle; reads issue only while a slot is guaranteed free.
    assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_next_quad = r_src_base + ADDR_WIDTH'(quad_offset(r_q + 2'd1, W));

    assign rd_en    = w_rd_en;
    assign rd_addr  = r_rd_addr;
    assign wr_valid = !w_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                w_rd_en = (w_occ < 3'd2);
                if (w_rd_en && w_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave as the final element is accepted so done lines up with it.
                if (!r_inflight && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)))
                    w_state_nxt = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_q             <= '0;
            r_c             <= '0;
            r_oy            <= '0;
            r_ox            <= '0;
            r_src_base      <= '0;
            r_rd_addr       <= '0;
            r_row_base      <= '0;
            r_chan_base     <= '0;
            r_wr_addr       <= '0;
            r_inflight_addr <= '0;
            r_inflight      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if ((r_state == IDLE) && start) begin
                r_q         <= '0;
                r_c         <= '0;
                r_oy        <= '0;
                r_ox        <= '0;
                r_src_base  <= src_base;
                r_rd_addr   <= src_base;
                r_row_base  <= src_base;
                r_chan_base <= src_base;
                r_wr_addr   <= dst_base;
            end
            if (w_rd_en) begin
                r_inflight_addr <= r_wr_addr;
                r_wr_addr       <= r_wr_addr + ADDR_WIDTH'(1);
                if (r_ox != OX_LAST) begin
                    r_ox      <= r_ox + OXW'(1);
                    r_rd_addr <= r_rd_addr + COL_STEP;
                end else if (r_oy != OY_LAST) begin
                    r_ox       <= '0;
                    r_oy       <= r_oy + OYW'(1);
                    r_row_base <= r_row_base + ROW_STEP;
                    r_rd_addr  <= r_row_base + ROW_STEP;
                end else if (r_c != C_LAST) begin
                    r_ox        <= '0;
                    r_oy        <= '0;
                    r_c         <= r_c + CW'(1);
                    r_chan_base <= r_chan_base + CH_STEP;
                    r_row_base  <= r_chan_base + CH_STEP;
                    r_rd_addr   <= r_chan_base + CH_STEP;
                end else begin
                    r_ox        <= '0;
                    r_oy        <= '0;
                    r_c         <= '0;
                    r_q         <= r_q + 2'd1;
                    r_chan_base <= w_next_quad;
                    r_row_base  <= w_next_quad;
                    r_rd_addr   <= w_next_quad;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(r_inflight && w_full && !w_pop));
        end
    end

    slice_ofifo #(
        .AW(ADDR_WIDTH),
        .DW(DATA_WIDTH)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_addr (r_inflight_addr),
        .push_data (rd_data),
        .pop       (w_pop),
        .head_addr (wr_addr),
        .head_data (wr_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
